// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target.
package i2c_pkg;
   localparam int C_I2C_ADDR_W = 7;
   localparam int C_I2C_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } t_i2c_slv_state;
endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a run-length glitch filter for one I2C line.
// Edge pulses assert in the same cycle the filtered level changes.
module i2c_line_filter #(
   parameter int G_FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = (G_FILTER_LEN > 1) ? $clog2(G_FILTER_LEN) : 1;

   logic [1:0]    sync_q;
   logic          lvl_q, rise_q, fall_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         lvl_q  <= 1'b1;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], i_line};
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         // any sample equal to the current level restarts the run
         if (sync_q[1] == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(G_FILTER_LEN - 1)) begin
            lvl_q  <= sync_q[1];
            cnt_q  <= '0;
            rise_q <= sync_q[1];
            fall_q <= ~sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign o_level = lvl_q;
   assign o_rise  = rise_q;
   assign o_fall  = fall_q;
endmodule

// File: rtl/i2c_slave.sv
// 7-bit address I2C target with a byte-wide write/read side interface.
// SDA is only changed after a filtered SCL fall, so it never moves while SCL is high.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [C_I2C_ADDR_W-1:0] G_CHIP_ADDR  = 7'h50,
   parameter int                      G_FILTER_LEN = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_scl,
   input  logic                    i_sda,
   output logic                    o_sda_oe,
   output logic [C_I2C_BYTE_W-1:0] o_wdata,
   output logic                    o_wdata_valid,
   output logic                    o_rdata_req,
   input  logic [C_I2C_BYTE_W-1:0] i_rdata,
   output logic                    o_addr_match,
   output logic                    o_rw,
   output logic                    o_stop_det,
   output logic                    o_busy
);
   logic scl_lvl, scl_rise, scl_fall, scl_unused;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   i2c_line_filter #(.G_FILTER_LEN(G_FILTER_LEN)) u_scl (
      .clk(clk), .rst(rst), .i_line(i_scl),
      .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
   );
   i2c_line_filter #(.G_FILTER_LEN(G_FILTER_LEN)) u_sda (
      .clk(clk), .rst(rst), .i_line(i_sda),
      .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
   );
   assign scl_unused = 1'b0;

   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   t_i2c_slv_state          state_q;
   logic [2:0]              bitcnt_q;
   logic [C_I2C_BYTE_W-1:0] shift_q, wdata_q;
   logic                    pend_q, oe_q, wvld_q, rreq_q, match_q, rw_q, stopdet_q, busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         wdata_q   <= '0;
         pend_q    <= 1'b0;
         oe_q      <= 1'b0;
         wvld_q    <= 1'b0;
         rreq_q    <= 1'b0;
         match_q   <= 1'b0;
         rw_q      <= 1'b0;
         stopdet_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         wvld_q    <= 1'b0;
         rreq_q    <= 1'b0;
         match_q   <= 1'b0;
         stopdet_q <= 1'b0;
         if (start) begin
            state_q  <= ADDR;
            bitcnt_q <= '0;
            pend_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b1;
         end else if (stop) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            oe_q      <= 1'b0;
            stopdet_q <= 1'b1;
            busy_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: ;
               ADDR, WR_BYTE: begin
                  if (scl_rise) begin
                     shift_q  <= {shift_q[6:0], sda_lvl};
                     bitcnt_q <= bitcnt_q + 3'd1;
                     if (bitcnt_q == 3'd7) begin
                        if (state_q == WR_BYTE) begin
                           wdata_q <= {shift_q[6:0], sda_lvl};
                           wvld_q  <= 1'b1;
                           pend_q  <= 1'b1;
                        end else if (shift_q[6:0] == G_CHIP_ADDR) begin
                           match_q <= 1'b1;
                           rw_q    <= sda_lvl;
                           pend_q  <= 1'b1;
                        end else begin
                           state_q <= WAIT_STOP;
                        end
                     end
                  end else if (scl_fall && pend_q) begin
                     // ACK slot: pull SDA low for the 9th clock
                     oe_q    <= 1'b1;
                     pend_q  <= 1'b0;
                     state_q <= (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                  end
               end
               ADDR_ACK: begin
                  if (scl_rise && rw_q) begin
                     rreq_q <= 1'b1;
                  end else if (scl_fall) begin
                     if (rw_q) begin
                        shift_q  <= i_rdata;
                        oe_q     <= ~i_rdata[7];
                        bitcnt_q <= '0;
                        state_q  <= RD_BYTE;
                     end else begin
                        oe_q    <= 1'b0;
                        state_q <= WR_BYTE;
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     oe_q    <= 1'b0;
                     state_q <= WR_BYTE;
                  end
               end
               RD_BYTE: begin
                  if (scl_fall) begin
                     if (bitcnt_q == 3'd7) begin
                        oe_q     <= 1'b0;
                        bitcnt_q <= '0;
                        state_q  <= RD_ACK;
                     end else begin
                        shift_q  <= {shift_q[6:0], shift_q[7]};
                        oe_q     <= ~shift_q[6];
                        bitcnt_q <= bitcnt_q + 3'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_lvl) begin
                        rreq_q <= 1'b1;
                        pend_q <= 1'b1;
                     end else begin
                        oe_q    <= 1'b0;
                        state_q <= WAIT_STOP;
                     end
                  end else if (scl_fall && pend_q) begin
                     shift_q  <= i_rdata;
                     oe_q     <= ~i_rdata[7];
                     bitcnt_q <= '0;
                     pend_q   <= 1'b0;
                     state_q  <= RD_BYTE;
                  end
               end
               WAIT_STOP: oe_q <= 1'b0;
               default:   state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_sda_oe      = oe_q | scl_unused;
   assign o_wdata       = wdata_q;
   assign o_wdata_valid = wvld_q;
   assign o_rdata_req   = rreq_q;
   assign o_addr_match  = match_q;
   assign o_rw          = rw_q;
   assign o_stop_det    = stopdet_q;
   assign o_busy        = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master on a wired-AND SDA, scoreboard queues for side-band data.
module tb_i2c_slave;
   logic       clk = 1'b0, rst = 1'b1;
   logic       scl_m = 1'b1, sda_m = 1'b1;
   logic [7:0] rdata = 8'h00;
   logic       sda_oe, wvld, rreq, match, rw, stopdet, busy;
   logic [7:0] wdata;
   logic       sda_line;
   bit         glitch = 1'b0;

   assign sda_line = sda_m & ~sda_oe;
   always #5 clk = ~clk;

   i2c_slave #(.G_CHIP_ADDR(7'h50), .G_FILTER_LEN(3)) dut (
      .clk(clk), .rst(rst), .i_scl(scl_m), .i_sda(sda_line),
      .o_sda_oe(sda_oe), .o_wdata(wdata), .o_wdata_valid(wvld),
      .o_rdata_req(rreq), .i_rdata(rdata), .o_addr_match(match),
      .o_rw(rw), .o_stop_det(stopdet), .o_busy(busy)
   );

   int n_tests = 0, n_fail = 0;
   int n_req = 0, n_stop = 0, n_match = 0;
   logic [7:0] exp_wr[$], exp_rd[$], rd_src[$];
   logic       exp_rw[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wvld) begin
         if (exp_wr.size() != 0) chk("wdata", wdata, exp_wr.pop_front());
         else chk("wdata_unexpected", 1, 0);
      end
      if (match) begin
         n_match++;
         if (exp_rw.size() != 0) chk("rw", rw, exp_rw.pop_front());
         else chk("match_unexpected", 1, 0);
      end
      if (rreq) begin
         n_req++;
         if (rd_src.size() != 0) begin
            rdata = rd_src.pop_front();
            exp_rd.push_back(rdata);
         end else chk("rdata_req_unexpected", 1, 0);
      end
      if (stopdet) n_stop++;
   end

   task automatic dly(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      dly(5);
      sda_m = b;
      if (glitch) begin
         dly(3); scl_m = 1'b1; dly(1); scl_m = 1'b0; dly(11);
      end else dly(15);
      scl_m = 1'b1;
      dly(10);
      s = sda_line;
      if (glitch) begin
         scl_m = 1'b0; dly(1); scl_m = 1'b1; dly(9);
      end else dly(10);
      scl_m = 1'b0;
   endtask

   task automatic sta();
      if (!scl_m) begin
         dly(5); sda_m = 1'b1; dly(10); scl_m = 1'b1;
      end
      dly(20); sda_m = 1'b0; dly(20); scl_m = 1'b0;
   endtask

   task automatic sto();
      dly(5); sda_m = 1'b0; dly(15); scl_m = 1'b1; dly(20); sda_m = 1'b1; dly(20);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(nack, s);
   endtask

   task automatic rd_chk(input logic [7:0] d);
      if (exp_rd.size() != 0) chk("rdata_on_sda", d, exp_rd.pop_front());
      else chk("rdata_missing", 1, 0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      dly(4);
      chk("rst_oe", sda_oe, 0);
      chk("rst_outs", {wvld, rreq, match, rw, stopdet, busy, wdata}, 0);
      rst = 1'b0;
      dly(10);

      // two-byte write
      exp_rw.push_back(1'b0);
      sta();
      dly(2);
      chk("busy_after_start", busy, 1);
      wr_byte(8'hA0, ack); chk("wr_addr_ack", ack, 0);
      exp_wr.push_back(8'h12);
      wr_byte(8'h12, ack); chk("wr_ack0", ack, 0);
      exp_wr.push_back(8'h34);
      wr_byte(8'h34, ack); chk("wr_ack1", ack, 0);
      sto();
      chk("wr_stop_det", n_stop, 1);
      chk("wr_busy_end", busy, 0);
      chk("wr_match_cnt", n_match, 1);
      chk("wr_wdata_left", exp_wr.size(), 0);

      // address mismatch
      n_match = 0;
      sta();
      wr_byte(8'hA2, ack); chk("mis_addr_nack", ack, 1);
      wr_byte(8'h12, ack); chk("mis_data_nack", ack, 1);
      chk("mis_oe", sda_oe, 0);
      sto();
      chk("mis_match_cnt", n_match, 0);
      chk("mis_stop_det", n_stop, 2);

      // three-byte read
      n_req = 0;
      rd_src = '{8'hC5, 8'h3A, 8'hFF};
      exp_rw.push_back(1'b1);
      sta();
      wr_byte(8'hA1, ack); chk("rd_addr_ack", ack, 0);
      rd_byte(1'b0, d); rd_chk(d);
      rd_byte(1'b0, d); rd_chk(d);
      rd_byte(1'b1, d); rd_chk(d);
      dly(10);
      chk("rd_release_after_nack", sda_oe, 0);
      sto();
      chk("rd_req_cnt", n_req, 3);

      // write then repeated START into a read
      n_req = 0; n_match = 0;
      exp_rw.push_back(1'b0);
      sta();
      wr_byte(8'hA0, ack); chk("sr_wr_addr_ack", ack, 0);
      exp_wr.push_back(8'h07);
      wr_byte(8'h07, ack); chk("sr_wr_ack", ack, 0);
      exp_rw.push_back(1'b1);
      rd_src.push_back(8'h96);
      sta();
      wr_byte(8'hA1, ack); chk("sr_rd_addr_ack", ack, 0);
      rd_byte(1'b1, d); rd_chk(d);
      sto();
      chk("sr_wdata", wdata, 8'h07);
      chk("sr_match_cnt", n_match, 2);
      chk("sr_req_cnt", n_req, 1);

      // glitches on SCL during a write
      glitch = 1'b1;
      exp_rw.push_back(1'b0);
      sta();
      wr_byte(8'hA0, ack); chk("gl_addr_ack", ack, 0);
      exp_wr.push_back(8'h55);
      wr_byte(8'h55, ack); chk("gl_data_ack", ack, 0);
      glitch = 1'b0;
      sto();
      chk("gl_wdata", wdata, 8'h55);
      chk("gl_wdata_left", exp_wr.size(), 0);

      // reset while driving a 0 read bit
      rd_src.push_back(8'h0F);
      exp_rw.push_back(1'b1);
      sta();
      wr_byte(8'hA1, ack); chk("rst_rd_addr_ack", ack, 0);
      dly(10);
      chk("rst_rd_driving", sda_oe, 1);
      rst = 1'b1;
      dly(1);
      chk("rst_mid_oe", sda_oe, 0);
      chk("rst_mid_busy", busy, 0);
      dly(2);
      rst = 1'b0;
      exp_rd.delete();
      rd_src.delete();
      sda_m = 1'b1;
      dly(5); scl_m = 1'b1; dly(20);
      exp_rw.push_back(1'b0);
      sta();
      wr_byte(8'hA0, ack); chk("post_rst_addr_ack", ack, 0);
      exp_wr.push_back(8'h5A);
      wr_byte(8'h5A, ack); chk("post_rst_ack", ack, 0);
      sto();
      chk("post_rst_wdata", wdata, 8'h5A);
      chk("post_rst_busy", busy, 0);

      chk("rw_left", exp_rw.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
